// File: rtl/frame_dispatcher_pkg.sv
// Shared frame-fetch definitions: frame geometry, FSM encoding and helpers.
package frame_dispatcher_pkg;

  localparam int unsigned FRAME_ROW_CNUM  = 30;
  localparam int unsigned CELL_ROW_PNUM   = 8;
  localparam int unsigned FRAME_COL_PGNUM = 10;
  localparam int unsigned FRAME_PGNUM     = FRAME_ROW_CNUM * CELL_ROW_PNUM * FRAME_COL_PGNUM;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fd_state_e;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_lane_arbiter.sv
// Round-robin lane picker: first requesting lane at or after rr_ptr, wrapping.
module rr_lane_arbiter
  import frame_dispatcher_pkg::*;
#(
  parameter int unsigned IP_AMT   = 2,
  parameter int unsigned IP_IDX_W = 1
) (
  input  logic [IP_AMT-1:0]   req,
  input  logic [IP_IDX_W-1:0] rr_ptr,
  output logic [IP_IDX_W-1:0] grant_idx,
  output logic                grant_any
);

  // Walk lanes starting at rr_ptr; the first requester wins.
  always_comb begin
    int unsigned k;
    k         = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < IP_AMT; i++) begin
      k = (32'(rr_ptr) + i) % IP_AMT;
      if (!grant_any && req[IP_IDX_W'(k)]) begin
        grant_any = 1'b1;
        grant_idx = IP_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Steers whole frames of the broadcast pixel-group stream to free lanes, round-robin.
module frame_dispatcher
  import frame_dispatcher_pkg::*;
#(
  parameter int unsigned IP_AMT          = 2,
  parameter int unsigned FRAME_ROW_CNUM  = frame_dispatcher_pkg::FRAME_ROW_CNUM,
  parameter int unsigned CELL_ROW_PNUM   = frame_dispatcher_pkg::CELL_ROW_PNUM,
  parameter int unsigned FRAME_COL_PGNUM = frame_dispatcher_pkg::FRAME_COL_PGNUM,
  localparam int unsigned FRAME_PGNUM    = FRAME_ROW_CNUM * CELL_ROW_PNUM * FRAME_COL_PGNUM,
  localparam int unsigned PG_CNT_W       = idx_width(FRAME_PGNUM),
  localparam int unsigned IP_IDX_W       = idx_width(IP_AMT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pgroup_valid_i,
  output logic                pgroup_ready_o,
  input  logic [IP_AMT-1:0]   ip_pgroup_ready_i,
  input  logic [IP_AMT-1:0]   ip_frame_complete_i,
  output logic [IP_AMT-1:0]   ip_pgroup_valid_o,
  output logic [IP_IDX_W-1:0] active_ip_o,
  output logic                frame_start_o,
  output logic                frame_done_o,
  output logic                all_busy_o
);

  localparam logic [PG_CNT_W-1:0] PG_LAST  = PG_CNT_W'(FRAME_PGNUM - 1);
  localparam logic [IP_IDX_W-1:0] IDX_LAST = IP_IDX_W'(IP_AMT - 1);

  fd_state_e             state, state_next;
  logic [IP_AMT-1:0]     busy, busy_next, set_mask;
  logic [PG_CNT_W-1:0]   pg_cnt, pg_cnt_next;
  logic [IP_IDX_W-1:0]   rr_ptr, rr_ptr_next;
  logic [IP_IDX_W-1:0]   sel, sel_next;
  logic [IP_IDX_W-1:0]   grant_idx;
  logic                  grant_any;

  rr_lane_arbiter #(
    .IP_AMT   (IP_AMT),
    .IP_IDX_W (IP_IDX_W)
  ) u_arb (
    .req       (~busy),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Lane selection, beat counter, round-robin pointer and busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      pg_cnt <= '0;
      rr_ptr <= '0;
      sel    <= '0;
    end else begin
      busy   <= busy_next;
      pg_cnt <= pg_cnt_next;
      rr_ptr <= rr_ptr_next;
      sel    <= sel_next;
    end
  end

  // Next-state and handshake steering; everything is quiet while rst is held.
  always_comb begin
    state_next        = state;
    sel_next          = sel;
    pg_cnt_next       = pg_cnt;
    rr_ptr_next       = rr_ptr;
    set_mask          = '0;
    pgroup_ready_o    = 1'b0;
    ip_pgroup_valid_o = '0;
    frame_start_o     = 1'b0;
    frame_done_o      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            sel_next      = grant_idx;
            state_next    = STREAM;
            frame_start_o = 1'b1;
          end
        end
        STREAM: begin
          ip_pgroup_valid_o[sel] = pgroup_valid_i;
          pgroup_ready_o         = ip_pgroup_ready_i[sel];
          if (pgroup_valid_i && ip_pgroup_ready_i[sel]) begin
            if (pg_cnt == PG_LAST) begin
              pg_cnt_next   = '0;
              set_mask[sel] = 1'b1;
              rr_ptr_next   = (sel == IDX_LAST) ? '0 : sel + IP_IDX_W'(1);
              frame_done_o  = 1'b1;
              state_next    = IDLE;
            end else begin
              pg_cnt_next = pg_cnt + PG_CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Set wins over a same-cycle completion; completions on idle lanes are no-ops.
  assign busy_next   = (busy & ~ip_frame_complete_i) | set_mask;
  assign all_busy_o  = &busy;
  assign active_ip_o = sel;

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher with a 4-beat frame and two lanes.
module tb_frame_dispatcher;
  import frame_dispatcher_pkg::*;

  localparam int unsigned IP_AMT = 2;
  localparam int unsigned NBEATS = 4;

  logic       clk;
  logic       rst;
  logic       pgroup_valid_i;
  logic       pgroup_ready_o;
  logic [1:0] ip_pgroup_ready_i;
  logic [1:0] ip_frame_complete_i;
  logic [1:0] ip_pgroup_valid_o;
  logic [0:0] active_ip_o;
  logic       frame_start_o;
  logic       frame_done_o;
  logic       all_busy_o;

  int checks = 0;
  int errors = 0;
  logic exp_lane_q[$];

  frame_dispatcher #(
    .IP_AMT          (IP_AMT),
    .FRAME_ROW_CNUM  (1),
    .CELL_ROW_PNUM   (1),
    .FRAME_COL_PGNUM (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pgroup_valid_i      (pgroup_valid_i),
    .pgroup_ready_o      (pgroup_ready_o),
    .ip_pgroup_ready_i   (ip_pgroup_ready_i),
    .ip_frame_complete_i (ip_frame_complete_i),
    .ip_pgroup_valid_o   (ip_pgroup_valid_o),
    .active_ip_o         (active_ip_o),
    .frame_start_o       (frame_start_o),
    .frame_done_o        (frame_done_o),
    .all_busy_o          (all_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] lane_oh(input logic lane);
    return lane ? 2'b10 : 2'b01;
  endfunction

  // Wait for a grant, then stream one frame; w returns idle cycles before the grant.
  task automatic do_frame(input logic lane, input bit toggle, input bit clr_last, output int w);
    bit   got;
    int   beats;
    logic rdy;
    logic exp_lane;
    exp_lane_q.push_back(lane);
    pgroup_valid_i = 1'b1;
    got = 0;
    w   = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      check("idle_ready", 32'(pgroup_ready_o), 32'(0));
      check("idle_valid", 32'(ip_pgroup_valid_o), 32'(0));
      if (frame_start_o) got = 1;
      else w++;
      cyc();
    end
    check("frame_start_seen", 32'(got), 32'(1));
    exp_lane = exp_lane_q[0];
    beats = 0;
    for (int c = 0; c < 40 && beats < int'(NBEATS); c++) begin
      rdy = toggle ? ~c[0] : 1'b1;
      ip_pgroup_ready_i   = {rdy, rdy};
      ip_frame_complete_i = (clr_last && beats == int'(NBEATS) - 1) ? lane_oh(lane) : 2'b00;
      #1;
      check("active_ip", 32'(active_ip_o), 32'(exp_lane));
      check("lane_valid", 32'(ip_pgroup_valid_o), 32'(lane_oh(exp_lane)));
      check("pg_ready", 32'(pgroup_ready_o), 32'(rdy));
      if (pgroup_ready_o) beats++;
      check("frame_done", 32'(frame_done_o), 32'(rdy && beats == int'(NBEATS)));
      cyc();
    end
    check("beat_count", 32'(beats), 32'(NBEATS));
    ip_frame_complete_i = 2'b00;
    ip_pgroup_ready_i   = 2'b11;
    void'(exp_lane_q.pop_front());
  endtask

  initial begin
    int w;
    rst                 = 1'b1;
    pgroup_valid_i      = 1'b0;
    ip_pgroup_ready_i   = 2'b11;
    ip_frame_complete_i = 2'b00;
    cyc();
    cyc();
    #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_ready", 32'(pgroup_ready_o), 32'(0));
    check("rst_valid", 32'(ip_pgroup_valid_o), 32'(0));
    check("rst_start", 32'(frame_start_o), 32'(0));
    check("rst_done", 32'(frame_done_o), 32'(0));
    check("rst_all_busy", 32'(all_busy_o), 32'(0));
    check("rst_active", 32'(active_ip_o), 32'(0));
    cyc();
    rst = 1'b0;

    // Back-to-back frames: lane 0 then lane 1, single bubble between.
    do_frame(1'b0, 1'b0, 1'b0, w);
    check("first_grant_wait", 32'(w), 32'(0));
    do_frame(1'b1, 1'b0, 1'b0, w);
    check("bubble_wait", 32'(w), 32'(0));

    // All lanes busy: valid held, nothing accepted.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_ready", 32'(pgroup_ready_o), 32'(0));
      check("busy_all", 32'(all_busy_o), 32'(1));
      check("busy_start", 32'(frame_start_o), 32'(0));
      cyc();
    end
    ip_frame_complete_i = 2'b10;
    #1;
    check("cmpl_same_cycle_start", 32'(frame_start_o), 32'(0));
    cyc();
    ip_frame_complete_i = 2'b00;
    do_frame(1'b1, 1'b0, 1'b0, w);
    check("grant_after_cmpl", 32'(w), 32'(0));

    // Free lane 0 only; third-frame wrap with backpressure on lane 0.
    ip_frame_complete_i = 2'b01;
    cyc();
    ip_frame_complete_i = 2'b00;
    do_frame(1'b0, 1'b1, 1'b0, w);
    check("wrap_wait", 32'(w), 32'(0));
    check("rr_ptr_wrap", 32'(dut.rr_ptr), 32'(1));

    // Completion pulse coinciding with the last beat: set wins.
    ip_frame_complete_i = 2'b01;
    cyc();
    ip_frame_complete_i = 2'b00;
    do_frame(1'b0, 1'b0, 1'b1, w);
    check("set_wins_busy", 32'(dut.busy), 32'(2'b11));
    check("set_wins_all_busy", 32'(all_busy_o), 32'(1));

    // Free lane 1, then pulse it again while it is not busy.
    pgroup_valid_i      = 1'b0;
    ip_frame_complete_i = 2'b10;
    cyc();
    #1;
    check("grant_lane1_start", 32'(frame_start_o), 32'(1));
    cyc();
    ip_frame_complete_i = 2'b00;
    #1;
    check("idle_cmpl_busy", 32'(dut.busy), 32'(2'b01));
    check("stream_lane1_state", 32'(dut.state), 32'(STREAM));
    check("stream_lane1_active", 32'(active_ip_o), 32'(1));
    cyc();

    // Two beats, then reset mid-frame.
    pgroup_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("pre_rst_ready", 32'(pgroup_ready_o), 32'(1));
      check("pre_rst_valid", 32'(ip_pgroup_valid_o), 32'(2'b10));
      cyc();
    end
    rst = 1'b1;
    cyc();
    #1;
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_busy", 32'(dut.busy), 32'(0));
    check("midrst_pg_cnt", 32'(dut.pg_cnt), 32'(0));
    check("midrst_ready", 32'(pgroup_ready_o), 32'(0));
    check("midrst_valid", 32'(ip_pgroup_valid_o), 32'(0));
    check("midrst_start", 32'(frame_start_o), 32'(0));
    check("midrst_done", 32'(frame_done_o), 32'(0));
    check("midrst_active", 32'(active_ip_o), 32'(0));
    check("midrst_all_busy", 32'(all_busy_o), 32'(0));
    cyc();
    rst = 1'b0;
    do_frame(1'b0, 1'b0, 1'b0, w);
    check("post_rst_wait", 32'(w), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_dispatcher.md
# frame_dispatcher

Schedules whole frames across the `IP_AMT` image-processor lanes of the frame-fetch subsystem. Sits between the AXI4 write-side controller and the per-lane cell controllers. The pixel-group data bus stays a broadcast bus; this block only steers the valid/ready handshake. It hands each incoming frame to one free lane in round-robin order, holds that lane for exactly one frame of pixel groups, and marks the lane busy until its cell controller reports frame completion.

## Interface
- `IP_AMT`, 2, number of image-processor lanes (≥1).
- `FRAME_ROW_CNUM`, 30, cell rows per frame.
- `CELL_ROW_PNUM`, 8, pixel rows per cell.
- `FRAME_COL_PGNUM`, 10, pixel groups per pixel row.
- `FRAME_PGNUM`, `FRAME_ROW_CNUM*CELL_ROW_PNUM*FRAME_COL_PGNUM` (2400), pixel groups per frame.
- `PG_CNT_W`, `$clog2(FRAME_PGNUM)`, beat counter width.
- `IP_IDX_W`, `(IP_AMT>1)?$clog2(IP_AMT):1`, lane index width.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `pgroup_valid_i` in 1: pixel group valid on shared bus (from AXI4 controller).
- `pgroup_ready_o` out 1: pixel group accepted.
- `ip_pgroup_ready_i` in `IP_AMT`: per-lane cell controller ready.
- `ip_frame_complete_i` in `IP_AMT`: per-lane one-cycle pulse, lane finished its frame.
- `ip_pgroup_valid_o` out `IP_AMT`: per-lane valid, at most one bit set.
- `active_ip_o` out `IP_IDX_W`: lane currently owning the stream.
- `frame_start_o` out 1: pulse, lane granted.
- `frame_done_o` out 1: pulse, last pixel group of frame accepted.
- `all_busy_o` out 1: every lane busy.

## Operation
- State machine with states IDLE and STREAM.
  - IDLE: if any lane is not busy, pick one with a round-robin search starting at `rr_ptr`. Latch its index into `sel` and go to STREAM. Pulse `frame_start_o` in the same cycle. If no lane is free, stay in IDLE.
  - STREAM: `ip_pgroup_valid_o[sel] = pgroup_valid_i` and `pgroup_ready_o = ip_pgroup_ready_i[sel]`. All other lanes see valid 0.
    - Each handshake (valid & ready) increments `pg_cnt`.
    - On the handshake with `pg_cnt == FRAME_PGNUM-1`:
      - clear `pg_cnt`;
      - set `busy[sel]`;
      - set `rr_ptr = (sel+1)` mod `IP_AMT`;
      - pulse `frame_done_o`;
      - go to IDLE.
- In IDLE, `pgroup_ready_o = 0` and `ip_pgroup_valid_o = 0`. Upstream stalls; no beat is lost or duplicated.
- Busy tracking: `busy_next = (busy & ~ip_frame_complete_i) | set_mask`. Set dominates a clear in the same cycle. A completion pulse on a non-busy lane is ignored.
- Wrap-around: `rr_ptr` wraps from `IP_AMT-1` to 0. The search wraps, and busy lanes are skipped.
- `all_busy_o = &busy`, combinational.
- `active_ip_o = sel`. Holds its last value in IDLE.
- `IP_AMT == 1`: degenerates to a single lane gated by its busy bit.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `pg_cnt`, `rr_ptr`, `sel` all 0;
  - all outputs 0, except that `all_busy_o` follows `busy`, so it is 0.
- `pgroup_ready_o` and `ip_pgroup_valid_o` are combinational from the inputs in STREAM. There are zero cycles of handshake latency, and no registered data path.
- Grant latency: one cycle after a lane frees. The completion pulse in cycle N clears busy at N+1. IDLE then grants at N+1, and `ip_pgroup_valid_o` can assert from N+2.
- Between back-to-back frames there is exactly one IDLE cycle, the bubble after `frame_done_o`, when a free lane exists.
- Upstream must hold `pgroup_valid_i` until `pgroup_ready_o`. The block has no dependency on valid-before-ready ordering.
- A reset asserted mid-frame aborts the frame and returns to IDLE on the next edge with all state cleared. The cell controllers are reset by the same `rst`.

## Structure
- Shared frame-fetch package/header holds `FRAME_PGNUM`, the frame geometry constants, and the state encodings (IDLE=0, STREAM=1). The cell controller reuses the same geometry.
- One sub-module: `rr_lane_arbiter`.
  - Combinational: inputs `req = ~busy` and `rr_ptr`; outputs `grant_idx` and `grant_any`.
  - The FSM, counter and busy register live in `frame_dispatcher`.

## Test plan
Benches use `IP_AMT=2` and `FRAME_PGNUM=4`, with the geometry parameters overridden so that 1×1×4 = 4.
- Reset, then a continuous valid stream with all lanes ready:
  - `frame_start_o` in cycle 1, `active_ip_o=0`;
  - 4 beats on lane 0;
  - `frame_done_o` on the 4th beat;
  - the next frame goes to lane 1.
- Both lanes busy, no completions: valid is held, `pgroup_ready_o` stays 0 and `all_busy_o=1`. A pulse on `ip_frame_complete_i[1]` leads to a lane-1 grant one cycle later.
- Lane backpressure with `ip_pgroup_ready_i[0]` toggling 1,0,1,0:
  - the beat count advances only on handshake cycles;
  - exactly 4 accepted beats, with no valid seen on lane 1.
- Round-robin wrap: complete lane 0 only, after frames on lanes 0 and 1. The third frame goes to lane 0 and `rr_ptr` returns to 1.
- Completion pulse on lane 0 in the same cycle that lane 0's frame ends (set and clear together): `busy[0]` stays 1. A completion pulse on an idle lane leaves `busy` unchanged.
- `rst` asserted after 2 beats of a frame: the next cycle shows IDLE, all outputs 0 and `busy=0`. The post-reset frame starts at lane 0 with `pg_cnt` from 0.
